spike_aer_encoder: RTL and testbench
====================================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001: Parameter N_NEURONS, default 16, number of neuron spike lines from the adlif neuron array (2..64).
REQ-002: Parameter FIFO_DEPTH, default 8, event buffer entries (power of two, >=2).
REQ-003: Parameter TS_W, default 16, timestamp width in bits.
REQ-004: One clock; reset is asynchronous and active-low.
REQ-005: clk  input  1  rising-edge clock.
REQ-006: rst_n  input  1  asynchronous active-low reset.
REQ-007: spike_in  input  N_NEURONS  per-neuron spike pulses, sampled every clk edge.
REQ-008: tick_in  input  1  simulation time-step strobe, one cycle per neuron time step.
REQ-009: ev_valid  output  1  event available at FIFO head.
REQ-010: ev_ready  input  1  downstream accepts the event.
REQ-011: ev_addr  output  $clog2(N_NEURONS)  index of the spiking neuron.
REQ-012: ev_ts  output  TS_W  timestamp of the event.
REQ-013: fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014: drop_count  output  16  spikes lost to pending-bit collision.

Function
REQ-015: Pending register: bit i SHALL be set on any clk edge where spike_in[i]=1.
REQ-016: Each cycle with any pending bit set and FIFO not full, a round-robin arbiter SHALL grant exactly one index: the lowest pending index >= rr_ptr, wrapping to 0.
REQ-017: On grant, the granted pending bit SHALL clear, {index, ts_cnt} SHALL be written to the FIFO, and rr_ptr SHALL become (grant+1) mod N_NEURONS.
REQ-018: If spike_in[g]=1 in the same cycle index g is granted, the bit SHALL remain set (new spike wins, no drop).
REQ-019: If spike_in[i]=1 while pending[i]=1 and i is not granted, drop_count SHALL increment by 1, saturating at 16'hFFFF; multiple simultaneous drops in one cycle add their count, saturating.
REQ-020: FIFO full SHALL block grants, even when a pop occurs in the same cycle.
REQ-021: Latency: spike sampled at edge k on an idle, empty block -> ev_valid=1 after edge k+2.
REQ-022: FIFO is show-ahead; pop on ev_valid && ev_ready; ev_addr/ev_ts SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-023: Simultaneous push and pop (not full) SHALL leave fifo_level unchanged.
REQ-024: ts_cnt SHALL increment by 1 on each clk edge with tick_in=1, wrapping modulo 2^TS_W; a grant in a tick cycle uses the pre-increment value.

Reset
REQ-025: rst_n=0 SHALL immediately clear pending, rr_ptr, ts_cnt, FIFO pointers, drop_count; ev_valid=0, ev_addr=0, ev_ts=0, fifo_level=0.
REQ-026: Reset mid-operation SHALL discard all buffered and pending events; no event is emitted after release until a new spike arrives.

Configuration
REQ-027: Macro AER_TIMESTAMP_EN defined: ts_cnt and FIFO timestamp field built, behaviour per REQ-024.
REQ-028: AER_TIMESTAMP_EN undefined: no ts_cnt or timestamp storage; ev_ts SHALL be constant 0; tick_in ignored.

Structure
REQ-029: Package aer_pkg SHALL hold the aer_event_t struct (addr, ts), default parameter constants, and the drop-counter width.
REQ-030: FIFO SHALL be sub-module aer_event_fifo (synchronous, show-ahead, level output); arbiter and pending logic stay in the top.

Verification
REQ-031: Single spike_in[3] pulse, ev_ready=1 -> ev_valid at edge k+2, ev_addr=3, ev_ts=current ts_cnt, then ev_valid=0.
REQ-032: spike_in=16'hFFFF for one cycle, ev_ready=1 -> 16 events addr 0..15 in order, one per cycle, drop_count=0.
REQ-033: ev_ready=0, 12 distinct spikes -> fifo_level saturates at 8, 4 bits remain pending; ev_ready=1 -> all 12 delivered, none lost.
REQ-034: spike_in[5] pulsed on two consecutive cycles while FIFO full -> drop_count=1; a third pulse in the grant cycle of index 5 -> no drop, second event addr 5.
REQ-035: 70000 tick_in pulses with TS_W=16 -> ts_cnt wraps to 4464; event ev_ts matches; with AER_TIMESTAMP_EN undefined ev_ts=0.
REQ-036: rst_n asserted with 5 events buffered -> outputs zero asynchronously; after release no ev_valid without new spikes.

Source files
------------

// File: rtl/aer_pkg.sv
// aer_pkg: shared event type, default parameters and drop-counter helpers
// for the spike AER encoder. Optional timestamp support in the top is
// controlled by the AER_TIMESTAMP_EN macro.
package aer_pkg;

  localparam int AER_N_NEURONS_DEF  = 16;
  localparam int AER_FIFO_DEPTH_DEF = 8;
  localparam int AER_TS_W_DEF       = 16;
  localparam int AER_ADDR_W_DEF     = $clog2(AER_N_NEURONS_DEF);

  localparam int AER_DROP_W     = 16;
  // Wide enough to count 64 simultaneous collisions in one cycle.
  localparam int AER_DROP_INC_W = 7;

  // Event layout for the default configuration; the top derives its own
  // layout from its parameters and hands it to the FIFO as a type parameter.
  typedef struct packed {
    logic [AER_ADDR_W_DEF-1:0] addr;
    logic [AER_TS_W_DEF-1:0]   ts;
  } aer_event_t;

  // Saturating accumulate used by the drop counter.
  function automatic logic [AER_DROP_W-1:0] drop_sat_add(
    input logic [AER_DROP_W-1:0]     acc,
    input logic [AER_DROP_INC_W-1:0] inc
  );
    logic [AER_DROP_W:0] sum;
    sum = {1'b0, acc} + {{(AER_DROP_W + 1 - AER_DROP_INC_W){1'b0}}, inc};
    return sum[AER_DROP_W] ? {AER_DROP_W{1'b1}} : sum[AER_DROP_W-1:0];
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: synchronous show-ahead event buffer. The head entry is
// presented combinationally whenever the buffer is non-empty; level reports
// occupancy. Pushes into a full buffer and pops from an empty one are ignored.
module aer_event_fifo
  import aer_pkg::*;
#(
  parameter int  DEPTH = AER_FIFO_DEPTH_DEF,
  parameter type T     = aer_event_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int IW = $clog2(DEPTH);

  T            mem [DEPTH];
  logic [IW:0] wr_ptr;
  logic [IW:0] rd_ptr;
  logic        full;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[IW-1:0]];

  // Event storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[IW-1:0]] <= wr_data;
    end
  end

  // Read/write pointer advance; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: collects per-neuron spike pulses into a pending
// register, serialises them with a round-robin arbiter and buffers
// {address, timestamp} events for a ready/valid consumer.
// Define AER_TIMESTAMP_EN to build the tick-driven timestamp counter and the
// timestamp field of each event; without it ev_ts is tied to zero.
//
// Pipeline: spike registered into pending (edge k) -> grant registered into a
// one-entry push stage (edge k+1) -> written into the FIFO (edge k+2). The
// push stage counts toward occupancy so a granted event always has room.
module spike_aer_encoder
  import aer_pkg::*;
#(
  parameter int N_NEURONS  = AER_N_NEURONS_DEF,
  parameter int FIFO_DEPTH = AER_FIFO_DEPTH_DEF,
  parameter int TS_W       = AER_TS_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_NEURONS-1:0]         spike_in,
  input  logic                         tick_in,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [$clog2(N_NEURONS)-1:0] ev_addr,
  output logic [TS_W-1:0]              ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [AER_DROP_W-1:0]        drop_count
);

  localparam int AW = $clog2(N_NEURONS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

`ifdef AER_TIMESTAMP_EN
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [TS_W-1:0] ts;
  } ev_t;
`else
  typedef struct packed {
    logic [AW-1:0] addr;
  } ev_t;
`endif

  logic [N_NEURONS-1:0]      pending;
  logic [N_NEURONS-1:0]      grant_oh;
  logic [N_NEURONS-1:0]      drop_vec;
  logic [AW-1:0]             rr_ptr;
  logic [AW-1:0]             grant_idx;
  logic [AW-1:0]             hi_idx;
  logic [AW-1:0]             lo_idx;
  logic                      hi_v;
  logic                      lo_v;
  logic                      grant_v;
  logic                      blocked;
  logic [LW:0]               occupancy;
  logic [AER_DROP_INC_W-1:0] drop_inc;
  logic                      push_v;
  ev_t                       push_ev;
  ev_t                       grant_ev;
  ev_t                       head_ev;
  logic                      fifo_empty;
  logic                      pop;

  // An in-flight push already owns a slot; a same-cycle pop does not free one.
  assign occupancy = {1'b0, fifo_level} + {{LW{1'b0}}, push_v};
  assign blocked   = (occupancy >= (LW + 1)'(FIFO_DEPTH));

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_v   = 1'b0;
    hi_idx = '0;
    lo_v   = 1'b0;
    lo_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_v   = 1'b1;
        lo_idx = AW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_v   = 1'b1;
          hi_idx = AW'(i);
        end
      end
    end
    grant_v   = lo_v && !blocked;
    grant_idx = hi_v ? hi_idx : lo_idx;
  end

  // One-hot form of the grant, used to clear the granted pending bit.
  always_comb begin
    grant_oh = '0;
    if (grant_v) grant_oh[grant_idx] = 1'b1;
  end

  // A spike on an already-pending, non-granted line is a lost event.
  assign drop_vec = spike_in & pending & ~grant_oh;

  // Count collisions in this cycle.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_inc = drop_inc + AER_DROP_INC_W'(drop_vec[i]);
    end
  end

  // Pending bits, arbiter pointer and drop counter; a new spike on the
  // granted line re-arms its bit instead of being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      pending    <= spike_in | (pending & ~grant_oh);
      drop_count <= drop_sat_add(drop_count, drop_inc);
      if (grant_v) begin
        rr_ptr <= (int'(grant_idx) == N_NEURONS - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Time-step counter; wraps naturally at 2^TS_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else if (tick_in) begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Event captured at grant time, so a tick in the same cycle is not yet seen.
  always_comb begin
    grant_ev      = '0;
    grant_ev.addr = grant_idx;
    grant_ev.ts   = ts_cnt;
  end

  assign ev_ts = ev_valid ? head_ev.ts : '0;
`else
  // tick_in has no effect without timestamps.
  logic tick_unused;
  assign tick_unused = tick_in;

  // Event carries only the neuron address.
  always_comb begin
    grant_ev      = '0;
    grant_ev.addr = grant_idx;
  end

  assign ev_ts = '0;
`endif

  // Push stage between the arbiter and the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_v  <= 1'b0;
      push_ev <= '0;
    end else begin
      push_v <= grant_v;
      if (grant_v) push_ev <= grant_ev;
    end
  end

  aer_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ev_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_v),
    .wr_data (push_ev),
    .pop     (pop),
    .rd_data (head_ev),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Outputs read as zero whenever no event is presented, including in reset.
  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  assign ev_addr  = ev_valid ? head_ev.addr : '0;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: scenario tasks for the spike AER encoder plus a
// queue-based reference model advanced once per clock edge.
module tb_spike_aer_encoder;

  localparam int N   = 16;
  localparam int D   = 8;
  localparam int TSW = 16;
`ifdef AER_TIMESTAMP_EN
  localparam int TS_ON = 1;
`else
  localparam int TS_ON = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   spike_in = '0;
  logic           tick_in = 1'b0;
  logic           ev_ready = 1'b0;
  logic           ev_valid;
  logic [3:0]     ev_addr;
  logic [TSW-1:0] ev_ts;
  logic [3:0]     fifo_level;
  logic [15:0]    drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  spike_aer_encoder #(
    .N_NEURONS  (N),
    .FIFO_DEPTH (D),
    .TS_W       (TSW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .tick_in    (tick_in),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_addr    (ev_addr),
    .ev_ts      (ev_ts),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    int ts;
  } mev_t;

  mev_t m_q[$];
  bit   m_pend[N];
  int   m_rr;
  bit   m_infl_v;
  mev_t m_infl;
  int   m_ts;
  int   m_drop;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_rr = 0;
    m_infl_v = 1'b0;
    m_infl.addr = 0;
    m_infl.ts = 0;
    m_ts = 0;
    m_drop = 0;
  endtask

  // One clock edge: grant from the pre-edge pending set, then update.
  task automatic model_step();
    bit pop;
    bit gv;
    int g;
    pop = (m_q.size() > 0) && ev_ready;
    gv = 1'b0;
    g = 0;
    if (m_q.size() + int'(m_infl_v) < D) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!gv && m_pend[i]) begin
          gv = 1'b1;
          g = i;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (spike_in[i] && m_pend[i] && !(gv && g == i)) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
    end
    for (int i = 0; i < N; i++) m_pend[i] = spike_in[i] || (m_pend[i] && !(gv && g == i));
    if (pop) void'(m_q.pop_front());
    if (m_infl_v) m_q.push_back(m_infl);
    m_infl_v = gv;
    m_infl.addr = g;
    m_infl.ts = m_ts;
    if (gv) m_rr = (g + 1) % N;
    if (TS_ON != 0 && tick_in) m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    spike_in = '0;
    tick_in = 1'b0;
    ev_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", ev_valid); end
    tests_run++; if (ev_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d want 0", ev_addr); end
    tests_run++; if (ev_ts !== 16'd0) begin tests_failed++; $display("FAIL reset_ts: got %0d want 0", ev_ts); end
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_valid: got %0b want 0", ev_valid); end
  endtask

  task automatic test_single();
    do_reset();
    tick_in = 1'b1;
    repeat (5) step();
    tick_in = 1'b0;
    ev_ready = 1'b1;
    spike_in = 16'h0008;
    step();
    spike_in = '0;
    step();
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL single_k1_valid: got %0b want 0", ev_valid); end
    step();
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("FAIL single_k2_valid: got %0b want 1", ev_valid); end
    tests_run++; if (ev_addr !== 4'd3) begin tests_failed++; $display("FAIL single_addr: got %0d want 3", ev_addr); end
    tests_run++; if (ev_ts !== 16'(TS_ON * 5)) begin tests_failed++; $display("FAIL single_ts: got %0d want %0d", ev_ts, TS_ON * 5); end
    step();
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after_valid: got %0b want 0", ev_valid); end
  endtask

  task automatic test_burst();
    int got[$];
    int first_c;
    int last_c;
    do_reset();
    ev_ready = 1'b1;
    spike_in = '1;
    step();
    spike_in = '0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (ev_valid === 1'b1) begin
        got.push_back(int'(ev_addr));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step();
    end
    tests_run++; if (got.size() != 16) begin tests_failed++; $display("FAIL burst_count: got %0d want 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      tests_run++; if (got[i] != i) begin tests_failed++; $display("FAIL burst_order[%0d]: got %0d want %0d", i, got[i], i); end
    end
    tests_run++; if (last_c - first_c != 15) begin tests_failed++; $display("FAIL burst_span: got %0d cycles want 15", last_c - first_c); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL burst_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_fill();
    int idx[16];
    logic [N-1:0] want_mask;
    logic [N-1:0] got_mask;
    logic [3:0] hold_addr;
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) idx[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    want_mask = '0;
    for (int k = 0; k < 12; k++) begin
      spike_in = 16'h0001 << idx[k];
      want_mask = want_mask | spike_in;
      step();
    end
    spike_in = '0;
    repeat (20) step();
    tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL fill_level: got %0d want 8", fifo_level); end
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("FAIL fill_valid: got %0b want 1", ev_valid); end
    hold_addr = ev_addr;
    repeat (3) step();
    tests_run++; if (ev_addr !== hold_addr) begin tests_failed++; $display("FAIL fill_stable: got %0d want %0d", ev_addr, hold_addr); end
    ev_ready = 1'b1;
    got_mask = '0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (ev_valid === 1'b1) begin
        n++;
        got_mask[ev_addr] = 1'b1;
        tests_run++; if (m_q.size() == 0 || ev_addr !== 4'(m_q[0].addr)) begin tests_failed++; $display("FAIL fill_event: got addr %0d want %0d", ev_addr, (m_q.size() > 0) ? m_q[0].addr : -1); end
      end
      step();
    end
    tests_run++; if (n != 12) begin tests_failed++; $display("FAIL fill_count: got %0d want 12", n); end
    tests_run++; if (got_mask !== want_mask) begin tests_failed++; $display("FAIL fill_set: got %h want %h", got_mask, want_mask); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL fill_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_drop();
    int got[$];
    int exp[$];
    do_reset();
    spike_in = 16'hFF00;
    step();
    spike_in = '0;
    for (int c = 0; c < 30 && fifo_level !== 4'd8; c++) step();
    tests_run++; if (fifo_level !== 4'd8) begin tests_failed++; $display("FAIL drop_fill_level: got %0d want 8", fifo_level); end
    repeat (2) step();
    spike_in = 16'h0020;
    step();
    step();
    spike_in = '0;
    tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL drop_collision: got %0d want 1", drop_count); end
    ev_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (ev_valid === 1'b1) got.push_back(int'(ev_addr));
      spike_in = (c == 1) ? 16'h0020 : 16'h0000;
      step();
    end
    spike_in = '0;
    for (int a = 8; a < 16; a++) exp.push_back(a);
    exp.push_back(5);
    exp.push_back(5);
    tests_run++; if (got.size() != exp.size()) begin tests_failed++; $display("FAIL drop_event_count: got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      tests_run++; if (got[i] != exp[i]) begin tests_failed++; $display("FAIL drop_order[%0d]: got %0d want %0d", i, got[i], exp[i]); end
    end
    tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL drop_regrant: got %0d want 1", drop_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 100; c++) begin
        logic [31:0] r;
        r = $urandom & $urandom;
        if (seg == 2) r = r & $urandom;
        spike_in = r[N-1:0];
        ev_ready = (seg == 1) ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0);
        tick_in = 1'($urandom_range(1, 0));
        step();
        tests_run++; if (ev_valid !== (m_q.size() > 0)) begin tests_failed++; $display("FAIL rand_valid: got %0b want %0b", ev_valid, m_q.size() > 0); end
        tests_run++; if (fifo_level !== 4'(m_q.size())) begin tests_failed++; $display("FAIL rand_level: got %0d want %0d", fifo_level, m_q.size()); end
        tests_run++; if (drop_count !== 16'(m_drop)) begin tests_failed++; $display("FAIL rand_drop: got %0d want %0d", drop_count, m_drop); end
        if (m_q.size() > 0) begin
          tests_run++; if (ev_addr !== 4'(m_q[0].addr)) begin tests_failed++; $display("FAIL rand_addr: got %0d want %0d", ev_addr, m_q[0].addr); end
          tests_run++; if (ev_ts !== 16'(m_q[0].ts)) begin tests_failed++; $display("FAIL rand_ts: got %0d want %0d", ev_ts, m_q[0].ts); end
        end
      end
    end
    spike_in = '0;
    tick_in = 1'b0;
  endtask

  task automatic test_ts_wrap();
    int c;
    do_reset();
    tick_in = 1'b1;
    repeat (70000) step();
    tick_in = 1'b0;
    ev_ready = 1'b1;
    spike_in = 16'h0008;
    step();
    spike_in = '0;
    c = 0;
    while (ev_valid !== 1'b1 && c < 10) begin
      step();
      c++;
    end
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("FAIL ts_wrap_valid: got %0b want 1", ev_valid); end
    tests_run++; if (ev_addr !== 4'd3) begin tests_failed++; $display("FAIL ts_wrap_addr: got %0d want 3", ev_addr); end
    tests_run++; if (ev_ts !== 16'(TS_ON * 4464)) begin tests_failed++; $display("FAIL ts_wrap_ts: got %0d want %0d", ev_ts, TS_ON * 4464); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    spike_in = 16'h2461;
    step();
    spike_in = 16'h2460;
    step();
    spike_in = '0;
    tests_run++; if (drop_count !== 16'd4) begin tests_failed++; $display("FAIL mid_pre_drop: got %0d want 4", drop_count); end
    for (int c = 0; c < 30 && fifo_level !== 4'd5; c++) step();
    tests_run++; if (fifo_level !== 4'd5) begin tests_failed++; $display("FAIL mid_pre_level: got %0d want 5", fifo_level); end
    spike_in = 16'h0200;
    step();
    spike_in = '0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %0b want 0", ev_valid); end
    tests_run++; if (ev_addr !== 4'd0) begin tests_failed++; $display("FAIL mid_addr: got %0d want 0", ev_addr); end
    tests_run++; if (ev_ts !== 16'd0) begin tests_failed++; $display("FAIL mid_ts: got %0d want 0", ev_ts); end
    tests_run++; if (fifo_level !== 4'd0) begin tests_failed++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ev_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_quiet[%0d]: got %0b want 0", c, ev_valid); end
    end
    spike_in = 16'h0080;
    step();
    spike_in = '0;
    step();
    step();
    tests_run++; if (ev_valid !== 1'b1 || ev_addr !== 4'd7) begin tests_failed++; $display("FAIL mid_new_event: got valid %0b addr %0d want valid 1 addr 7", ev_valid, ev_addr); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_drop();
    test_random();
    test_ts_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
